// File: rtl/q_operand_join.sv
// Operand join for the N/X/T -> Q stream: sticky N, one X paired with one T,
// Q = X*T + N (wrapping) delivered on a valid/ready channel with full backpressure.
module q_operand_join #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] N,
  input  logic              N_valid,
  output logic              N_ready,
  input  logic [DATA_W-1:0] X,
  input  logic              X_valid,
  output logic              X_ready,
  input  logic [DATA_W-1:0] T,
  input  logic              T_valid,
  output logic              T_ready,
  output logic [DATA_W-1:0] Q,
  output logic              Q_valid,
  input  logic              Q_ready,
  output logic [CNT_W-1:0]  q_count,
  output logic              busy
);

  typedef enum logic {COLLECT, OUT} state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] t_q, t_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              x_full_q, x_full_d;
  logic              t_full_q, t_full_d;
  logic [CNT_W-1:0]  q_count_q, q_count_d;

  logic              n_acc, x_acc, t_acc, q_hs, do_mac;
  logic [DATA_W-1:0] mac;

  // run_q keeps every ready low during reset and raises them one cycle after release
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= COLLECT;
      run_q     <= 1'b0;
      n_q       <= '0;
      x_q       <= '0;
      t_q       <= '0;
      q_q       <= '0;
      x_full_q  <= 1'b0;
      t_full_q  <= 1'b0;
      q_count_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      n_q       <= n_d;
      x_q       <= x_d;
      t_q       <= t_d;
      q_q       <= q_d;
      x_full_q  <= x_full_d;
      t_full_q  <= t_full_d;
      q_count_q <= q_count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    n_d       = n_q;
    x_d       = x_q;
    t_d       = t_q;
    q_d       = q_q;
    x_full_d  = x_full_q;
    t_full_d  = t_full_q;
    q_count_d = q_count_q;

    n_acc  = N_valid & run_q;
    x_acc  = X_valid & run_q & ~x_full_q;
    t_acc  = T_valid & run_q & ~t_full_q;
    q_hs   = (state_q == OUT) & Q_ready;
    do_mac = x_full_q & t_full_q & ((state_q == COLLECT) | q_hs);
    // Only the low DATA_W bits of the full product can reach Q, so they are all we form.
    mac    = x_q * t_q + n_q;

    if (n_acc) n_d = N;

    if (q_hs) begin
      q_count_d = q_count_q + CNT_W'(1);
      state_d   = COLLECT;
    end

    // Uses the pre-edge n_q, so an N accepted on this edge applies to the next result.
    if (do_mac) begin
      q_d      = mac;
      x_full_d = 1'b0;
      t_full_d = 1'b0;
      state_d  = OUT;
    end

    // Accepts never collide with do_mac: both need the opposite state of the full flag.
    if (x_acc) begin
      x_d      = X;
      x_full_d = 1'b1;
    end
    if (t_acc) begin
      t_d      = T;
      t_full_d = 1'b1;
    end
  end

  assign N_ready = run_q;
  assign X_ready = run_q & ~x_full_q;
  assign T_ready = run_q & ~t_full_q;
  assign Q       = q_q;
  assign Q_valid = (state_q == OUT);
  assign q_count = q_count_q;
  assign busy    = (state_q == OUT) | x_full_q | t_full_q;

endmodule

// File: tb/tb_q_operand_join.sv
// Bench for q_operand_join: directed scenarios with fixed expectations, then
// randomized traffic scored against a queue-based model of the pairing rules.
module tb_q_operand_join;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] N = '0, X = '0, T = '0;
  logic        N_valid = 1'b0, X_valid = 1'b0, T_valid = 1'b0, Q_ready = 1'b0;
  logic        N_ready, X_ready, T_ready, Q_valid, busy;
  logic [31:0] Q;
  logic [15:0] q_count;

  int checks = 0;
  int failures = 0;

  q_operand_join #(.DATA_W(32), .CNT_W(16)) dut (
    .aclk(aclk), .areset(areset),
    .N(N), .N_valid(N_valid), .N_ready(N_ready),
    .X(X), .X_valid(X_valid), .X_ready(X_ready),
    .T(T), .T_valid(T_valid), .T_ready(T_ready),
    .Q(Q), .Q_valid(Q_valid), .Q_ready(Q_ready),
    .q_count(q_count), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    areset = 1'b1;
    N_valid = 1'b0; X_valid = 1'b0; T_valid = 1'b0; Q_ready = 1'b0;
    tick();
    tick();
    check_eq({tag, "_rst_q"}, Q, 32'd0);
    check_eq({tag, "_rst_qv"}, 32'(Q_valid), 32'd0);
    check_eq({tag, "_rst_cnt"}, 32'(q_count), 32'd0);
    check_eq({tag, "_rst_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rst_rdy"}, {29'd0, N_ready, X_ready, T_ready}, 32'd0);
    areset = 1'b0;
    tick();
    check_eq({tag, "_run_rdy"}, {29'd0, N_ready, X_ready, T_ready}, 32'd7);
    $display("txn reset %s", tag);
  endtask

  task automatic send_n(input logic [31:0] v);
    N = v; N_valid = 1'b1;
    tick();
    N_valid = 1'b0;
    $display("txn N=%h", v);
  endtask

  task automatic send_xt(input logic [31:0] xv, input logic [31:0] tv);
    X = xv; T = tv; X_valid = 1'b1; T_valid = 1'b1;
    tick();
    X_valid = 1'b0; T_valid = 1'b0;
    $display("txn X=%h T=%h", xv, tv);
  endtask

  task automatic take_q(input string tag, input logic [31:0] exp);
    check_eq({tag, "_qv"}, 32'(Q_valid), 32'd1);
    check_eq({tag, "_q"}, Q, exp);
    Q_ready = 1'b1;
    tick();
    Q_ready = 1'b0;
    $display("txn Q=%h (%s)", exp, tag);
  endtask

  // scoreboard state for the random phase
  logic [31:0] xq[$];
  logic [31:0] tq[$];
  logic [31:0] expq[$];
  logic [31:0] n_m;
  int          hs_cnt;
  logic        xa, ta, na, qa, drain;

  initial begin
    // Basic
    do_reset("t1");
    send_xt(32'd1, 32'd2);
    check_eq("t1_lat", 32'(Q_valid), 32'd0);
    tick();
    take_q("t1", 32'd2);
    check_eq("t1_cnt", 32'(q_count), 32'd1);
    check_eq("t1_qv0", 32'(Q_valid), 32'd0);

    // Reversed order with sticky N
    send_n(32'd5);
    T = 32'd7; T_valid = 1'b1;
    tick();
    T_valid = 1'b0;
    tick();
    tick();
    check_eq("t2_busy", 32'(busy), 32'd1);
    X = 32'd3; X_valid = 1'b1;
    tick();
    X_valid = 1'b0;
    check_eq("t2_lat", 32'(Q_valid), 32'd0);
    tick();
    take_q("t2", 32'd26);
    check_eq("t2_cnt", 32'(q_count), 32'd2);

    // Backpressure
    do_reset("t3");
    send_xt(32'd2, 32'd4);
    tick();
    send_xt(32'd2, 32'd4);
    for (int i = 0; i < 9; i++) begin
      check_eq("t3_hold_q", Q, 32'd8);
      check_eq("t3_hold_qv", 32'(Q_valid), 32'd1);
      check_eq("t3_hold_rdy", {30'd0, X_ready, T_ready}, 32'd0);
      tick();
    end
    Q_ready = 1'b1;
    tick();
    Q_ready = 1'b0;
    check_eq("t3_b2b_cnt", 32'(q_count), 32'd1);
    check_eq("t3_b2b_rdy", {30'd0, X_ready, T_ready}, 32'd3);
    take_q("t3_second", 32'd8);
    check_eq("t3_cnt", 32'(q_count), 32'd2);
    check_eq("t3_qv0", 32'(Q_valid), 32'd0);

    // Overflow wraps
    do_reset("t4");
    send_n(32'd1);
    send_xt(32'h0001_0000, 32'h0001_0000);
    tick();
    take_q("t4", 32'd1);

    // N accepted on the compute edge
    do_reset("t5");
    X = 32'd2; T = 32'd3; X_valid = 1'b1; T_valid = 1'b1;
    tick();
    X_valid = 1'b0; T_valid = 1'b0;
    N = 32'd9; N_valid = 1'b1;
    tick();
    N_valid = 1'b0;
    take_q("t5_old_n", 32'd6);
    send_xt(32'd1, 32'd1);
    tick();
    check_eq("t5_new_n", Q, 32'd10);
    check_eq("t5_qv", 32'(Q_valid), 32'd1);

    // Reset while Q is pending
    areset = 1'b1;
    #1;
    check_eq("t6_qv", 32'(Q_valid), 32'd0);
    check_eq("t6_q", Q, 32'd0);
    check_eq("t6_cnt", 32'(q_count), 32'd0);
    tick();
    areset = 1'b0;
    tick();
    send_xt(32'd1, 32'd1);
    tick();
    take_q("t6", 32'd1);

    // Randomized traffic against the pairing model
    do_reset("rnd");
    n_m = 32'd0;
    hs_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge aclk);
      xa = X_valid && X_ready;
      ta = T_valid && T_ready;
      na = N_valid && N_ready;
      qa = Q_valid && Q_ready;
      if (qa) begin
        hs_cnt++;
        if (expq.size() == 0) check_eq("rnd_q_unexpected", 32'(expq.size()), 32'd1);
        else begin
          $display("txn rnd Q=%h", Q);
          check_eq("rnd_q", Q, expq.pop_front());
        end
      end
      if (na) n_m = N;
      if (xa) xq.push_back(X);
      if (ta) tq.push_back(T);
      while (xq.size() > 0 && tq.size() > 0) begin
        longint unsigned a, b;
        a = longint'(xq.pop_front());
        b = longint'(tq.pop_front());
        expq.push_back(32'((a * b + longint'(n_m)) % 64'h1_0000_0000));
      end
      @(posedge aclk);
      #1;
      drain = (i >= 560);
      if (!X_valid || xa) begin
        X_valid = !drain && ($urandom_range(0, 1) == 1);
        X = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      if (!T_valid || ta) begin
        T_valid = !drain && ($urandom_range(0, 1) == 1);
        T = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      // N changes only while nothing is in flight, so each result's N is unambiguous
      N_valid = !drain && !busy && ($urandom_range(0, 3) == 0);
      if (N_valid) N = $urandom;
      Q_ready = drain || ($urandom_range(0, 2) != 0);
    end
    check_eq("rnd_drained", 32'(expq.size()), 32'd0);
    check_eq("rnd_cnt", 32'(q_count), 32'(hs_cnt % 65536));
    check_eq("rnd_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
